// File: rtl/freq_divider_bank.sv
// Bank of NCH independent programmable clock dividers with glitch-free divisor updates.
// Optional bank-wide phase restart port `sync` is compiled in when FDIV_SYNC_EN is defined.
module freq_divider_bank #(
    parameter int NCH         = 4,
    parameter int CW          = 32,
    parameter int DEFAULT_DIV = 2500,
    localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  en,
    input  logic            wr_en,
    input  logic [SELW-1:0] wr_sel,
    input  logic [CW-1:0]   wr_data,
    output logic [NCH-1:0]  clk_div,
    output logic [NCH-1:0]  tick
`ifdef FDIV_SYNC_EN
    ,
    input  logic            sync
`endif
);

    localparam logic [CW-1:0] RST_DIV = CW'(DEFAULT_DIV);

    logic sync_s;

    // Bank-wide restart request; constant low when the feature is not built in.
    always_comb begin
`ifdef FDIV_SYNC_EN
        sync_s = sync;
`else
        sync_s = 1'b0;
`endif
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // Each channel decodes its own index, so out-of-range selects match no channel.
        localparam logic [SELW-1:0] IDX = SELW'(g);

        logic [CW-1:0] cnt_r, act_r, pend_r;
        logic [CW-1:0] cnt_s, act_s, pend_s, next_div_s;
        logic          div_r, div_s, tick_r, tick_s, hit_s;

        // Next-state decode: sync > terminal count > increment/hold.
        always_comb begin
            cnt_s      = cnt_r;
            act_s      = act_r;
            div_s      = div_r;
            tick_s     = 1'b0;
            hit_s      = wr_en && (wr_sel == IDX);
            next_div_s = hit_s ? wr_data : pend_r;
            pend_s     = next_div_s;
            if (sync_s) begin
                cnt_s = '0;
                div_s = 1'b0;
                act_s = next_div_s;
            end else if (en[g]) begin
                if (cnt_r == act_r) begin
                    cnt_s  = '0;
                    div_s  = ~div_r;
                    tick_s = 1'b1;
                    act_s  = next_div_s;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end else begin
                // A stopped channel has no half-period to protect, so writes apply at once.
                if (hit_s) begin
                    act_s = wr_data;
                end else begin
                    act_s = act_r;
                end
            end
        end

        // Channel state registers with asynchronous reset to the default divisor.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_r  <= '0;
                act_r  <= RST_DIV;
                pend_r <= RST_DIV;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_s;
                act_r  <= act_s;
                pend_r <= pend_s;
                div_r  <= div_s;
                tick_r <= tick_s;
            end
        end

        assign clk_div[g] = div_r;
        assign tick[g]    = tick_r;
    end

endmodule

// File: tb/tb_freq_divider_bank.sv
// Directed self-checking bench for freq_divider_bank (default NCH=4 instance plus a NCH=5 instance).
`timescale 1ns/1ps
module tb_freq_divider_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [31:0] wr_data;
    logic [3:0] clk_div;
    logic [3:0] tick;
    logic       sync;

    logic [4:0] en2;
    logic       wr_en2;
    logic [2:0] wr_sel2;
    logic [7:0] wr_data2;
    logic [4:0] clk_div2;
    logic [4:0] tick2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    freq_divider_bank dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .clk_div(clk_div), .tick(tick)
`ifdef FDIV_SYNC_EN
        , .sync(sync)
`endif
    );

    freq_divider_bank #(.NCH(5), .CW(8), .DEFAULT_DIV(3)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .wr_en(wr_en2), .wr_sel(wr_sel2),
        .wr_data(wr_data2), .clk_div(clk_div2), .tick(tick2)
`ifdef FDIV_SYNC_EN
        , .sync(sync)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; en = 4'b0000; wr_en = 1'b0; wr_sel = 2'd0; wr_data = 32'd0; sync = 1'b0;
        en2 = 5'b00000; wr_en2 = 1'b0; wr_sel2 = 3'd0; wr_data2 = 8'd0;
        nwait(2);
        check("rst_clk_div", 32'(clk_div), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);

        // First rise 2501 enabled cycles after release, fall 2501 later.
        rst = 1'b1; en = 4'b0001;
        nwait(2500);
        check("ch0_pre_rise", 32'(clk_div[0]), 32'h0);
        nwait(1);
        check("ch0_rise", 32'(clk_div[0]), 32'h1);
        check("ch0_tick_rise", 32'(tick[0]), 32'h1);
        nwait(1);
        check("ch0_tick_one_cycle", 32'(tick[0]), 32'h0);
        nwait(2499);
        check("ch0_pre_fall", 32'(clk_div[0]), 32'h1);
        nwait(1);
        check("ch0_fall", 32'(clk_div[0]), 32'h0);
        check("ch0_tick_fall", 32'(tick[0]), 32'h1);
        check("idle_channels", 32'(clk_div[3:1]), 32'h0);

        // Mid-period divisor write: current half-period unchanged, then 4-cycle halves.
        nwait(1000);
        wr_en = 1'b1; wr_sel = 2'd0; wr_data = 32'd3;
        nwait(1);
        wr_en = 1'b0;
        nwait(1499);
        check("ch0_half_kept", 32'(clk_div[0]), 32'h0);
        nwait(1);
        check("ch0_rise_after_write", 32'(clk_div[0]), 32'h1);
        nwait(3);
        check("ch0_short_pre_fall", 32'(clk_div[0]), 32'h1);
        nwait(1);
        check("ch0_short_fall", 32'(clk_div[0]), 32'h0);
        nwait(4);
        check("ch0_short_rise", 32'(clk_div[0]), 32'h1);

        // Disabled-channel write applies immediately; bypass write on terminal count.
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 32'd5;
        nwait(1);
        wr_en = 1'b0;
        en = 4'b0011;
        nwait(5);
        check("ch1_pre_tc", 32'(clk_div[1]), 32'h0);
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 32'd0;
        nwait(1);
        wr_en = 1'b0;
        check("ch1_tc_toggle", 32'(clk_div[1]), 32'h1);
        check("ch1_tc_tick", 32'(tick[1]), 32'h1);
        nwait(1);
        check("ch1_fast_0", 32'(clk_div[1]), 32'h0);
        check("ch1_fast_tick", 32'(tick[1]), 32'h1);
        nwait(1);
        check("ch1_fast_1", 32'(clk_div[1]), 32'h1);

        // Pause channel 2 for 10 cycles mid-count; period extends by exactly 10.
        wr_en = 1'b1; wr_sel = 2'd2; wr_data = 32'd4;
        nwait(1);
        wr_en = 1'b0;
        en = 4'b0111;
        nwait(2);
        en = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            nwait(1);
            check("ch2_hold_div", 32'(clk_div[2]), 32'h0);
            check("ch2_hold_tick", 32'(tick[2]), 32'h0);
        end
        en = 4'b0111;
        nwait(2);
        check("ch2_resume_pre", 32'(clk_div[2]), 32'h0);
        nwait(1);
        check("ch2_resume_rise", 32'(clk_div[2]), 32'h1);
        check("ch2_resume_tick", 32'(tick[2]), 32'h1);
        nwait(4);
        check("ch2_act_held_pre", 32'(clk_div[2]), 32'h1);
        nwait(1);
        check("ch2_act_held_fall", 32'(clk_div[2]), 32'h0);

        // Out-of-range write select on a 5-channel bank touches nothing.
        wr_en2 = 1'b1; wr_sel2 = 3'd7; wr_data2 = 8'd0;
        nwait(1);
        wr_en2 = 1'b0;
        en2 = 5'h1F;
        nwait(3);
        check("oob_pre_rise", 32'(clk_div2), 32'h0);
        nwait(1);
        check("oob_rise", 32'(clk_div2), 32'h1F);
        check("oob_tick", 32'(tick2), 32'h1F);

        // Asynchronous reset mid-period, then default divisor again.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_div", 32'(clk_div), 32'h0);
        check("async_rst_tick", 32'(tick), 32'h0);
        nwait(2);
        rst = 1'b1; en = 4'b0001;
        nwait(2500);
        check("post_rst_pre_rise", 32'(clk_div[0]), 32'h0);
        nwait(1);
        check("post_rst_rise", 32'(clk_div[0]), 32'h1);

`ifdef FDIV_SYNC_EN
        en = 4'b1111;
        nwait(300);
        sync = 1'b1;
        nwait(1);
        sync = 1'b0;
        check("sync_div", 32'(clk_div), 32'h0);
        check("sync_tick", 32'(tick), 32'h0);
        nwait(2500);
        check("sync_pre_rise", 32'(clk_div), 32'h0);
        nwait(1);
        check("sync_aligned_rise", 32'(clk_div), 32'hF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
